// File: rtl/dmaw_wdata_gen.sv
// dmaw_wdata_gen: streams awlen+1 write beats per accepted AW burst and tracks B responses.
module dmaw_wdata_gen #(
  parameter int AXI_DW     = 128,
  parameter int AXI_LW     = 8,
  parameter int AXI_IW     = 8,
  parameter int AXI_BRESPW = 2,
  parameter int AMI_OD     = 4,
  parameter int CMD_D      = 4,
  parameter int AXI_WSTRBW = AXI_DW / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [AXI_LW-1:0]     cmd_len,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [AXI_DW-1:0]     s_data,
  output logic [AXI_DW-1:0]     wdata,
  output logic [AXI_WSTRBW-1:0] wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [AXI_IW-1:0]     bid,
  input  logic [AXI_BRESPW-1:0] bresp,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic                  err_clr,
  output logic                  err,
  output logic                  idle
);
  localparam int AW = $clog2(CMD_D);
  localparam int CW = $clog2(CMD_D + 1);
  localparam int OW = $clog2(AMI_OD + 1);
  localparam logic [CW-1:0] DEPTH = CW'(CMD_D);
  localparam logic [OW-1:0] OD = OW'(AMI_OD);

  typedef enum logic {IDLE, DATA} state_t;
  state_t state, state_nxt;

  logic [AXI_LW-1:0] mem [CMD_D];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt;
  logic [OW-1:0]     ost_cnt;
  logic [AXI_LW-1:0] beat_cnt;
  logic              push, pop, empty, full, w_hs, b_hs, last;
  logic              unused_ok;

  assign unused_ok = ^{bid, bresp};
  assign empty     = cnt == '0;
  assign full      = cnt == DEPTH;
  assign cmd_ready = !full && ost_cnt < OD;
  assign push      = cmd_valid & cmd_ready;
  assign bready    = ost_cnt != '0;
  assign b_hs      = bvalid & bready;
  assign wvalid    = (state == DATA) & s_valid;
  assign s_ready   = (state == DATA) & wready;
  assign wdata     = s_data;
  assign wstrb     = '1;
  assign wlast     = (state == DATA) && beat_cnt == '0;
  assign w_hs      = wvalid & wready;
  assign last      = w_hs & wlast;
  assign idle      = state == IDLE && empty && ost_cnt == '0;

  // The next command is popped on the last beat so bursts run back to back.
  always_comb begin
    pop       = !empty && (state == IDLE || last);
    state_nxt = (state == IDLE || last) ? (empty ? IDLE : DATA) : state;
  end

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= cmd_len;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      ost_cnt  <= '0;
      beat_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      wr_ptr   <= wr_ptr + AW'(push);
      rd_ptr   <= rd_ptr + AW'(pop);
      cnt      <= cnt + CW'(push) - CW'(pop);
      ost_cnt  <= ost_cnt + OW'(push) - OW'(b_hs);
      beat_cnt <= pop ? mem[rd_ptr] : w_hs ? beat_cnt - AXI_LW'(1) : beat_cnt;
      err      <= (b_hs & bresp[1]) | (err & ~err_clr);
    end
endmodule

// File: tb/tb_dmaw_wdata_gen.sv
// tb_dmaw_wdata_gen: directed and randomized checks of dmaw_wdata_gen against a burst-level model.
module tb_dmaw_wdata_gen;
  localparam int AMI_OD = 4;
  localparam int CMD_D  = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid, cmd_ready;
  logic [7:0]   cmd_len;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [127:0] s_data = '0;
  logic [127:0] wdata;
  logic [15:0]  wstrb;
  logic         wlast, wvalid;
  logic         wready = 1'b0;
  logic [7:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid, bready, err_clr, err, idle;

  always #5 clk = ~clk;

  dmaw_wdata_gen #(.AMI_OD(AMI_OD), .CMD_D(CMD_D)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
    .bready(bready), .err_clr(err_clr), .err(err), .idle(idle)
  );

  int           n_tests = 0, n_fail = 0;
  logic [127:0] data_mem [1024];
  int           beats = 0, lasts = 0, seq = 0, exp_seq = 0, beat_pos = 0, m_ost = 0, pushes = 0;
  int           cyc = 0, first_cyc = 0, last_cyc = 0, s_mode = 0, w_mode = 0;
  int           len_q [$];
  int           last_pos [$];
  bit           m_err = 0, s_hs_flag = 0, prev_stall = 0, bh;
  logic [129:0] prev_w;

  task automatic check(input string tag, input logic [129:0] obs, input logic [129:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Burst-level reference: queue of pending burst lengths, outstanding count, sticky error.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      len_q.delete();
      beat_pos = 0; m_ost = 0; m_err = 0; s_hs_flag = 0; prev_stall = 0;
    end else begin
      check("cmd_ready", cmd_ready, m_ost < AMI_OD);
      check("bready", bready, m_ost != 0);
      check("idle", idle, m_ost == 0 && len_q.size() == 0);
      check("err", err, m_err);
      check("wstrb", wstrb, 16'hffff);
      if (len_q.size() == 0) check("w_outside_burst", {s_ready, wvalid}, 2'b00);
      if (prev_stall) check("w_stable", {wvalid, wlast, wdata}, prev_w);
      if (wvalid && wready && len_q.size() != 0) begin
        check("wdata", wdata, data_mem[exp_seq % 1024]);
        check("wlast", wlast, beat_pos == len_q[0]);
        exp_seq++; beats++; last_cyc = cyc;
        if (beats == 1) first_cyc = cyc;
        if (beat_pos == len_q[0]) begin
          lasts++; last_pos.push_back(beats); void'(len_q.pop_front()); beat_pos = 0;
        end else beat_pos++;
      end
      prev_stall = wvalid && !wready;
      prev_w = {wvalid, wlast, wdata};
      s_hs_flag = s_valid && s_ready;
      bh = bvalid && m_ost != 0;
      if (cmd_valid && m_ost < AMI_OD) begin
        len_q.push_back(int'(cmd_len)); m_ost++; pushes++;
      end
      if (bh) m_ost--;
      m_err = (bh && bresp[1]) ? 1'b1 : err_clr ? 1'b0 : m_err;
    end
  end

  // Upstream stream and W sink; s_valid is held until consumed.
  always begin
    @(posedge clk); #1;
    if (s_hs_flag) seq++;
    s_data = data_mem[seq % 1024];
    if (!s_valid || s_hs_flag) s_valid = (s_mode == 1) || (s_mode == 2 && $urandom_range(0, 3) != 0);
    wready = (w_mode == 1) || (w_mode == 2 && $urandom_range(0, 2) != 0);
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic sample(); @(negedge clk); #1; endtask

  task automatic send_cmd(input int len);
    int k = 0;
    bit ok = 0;
    tick();
    cmd_valid = 1; cmd_len = 8'(len);
    while (!ok && k < 200) begin sample(); ok = cmd_ready; tick(); k++; end
    cmd_valid = 0;
    check("cmd_accepted", ok, 1);
  endtask

  task automatic send_b(input logic [1:0] r);
    int k = 0;
    bit ok = 0;
    tick();
    bvalid = 1; bresp = r;
    while (!ok && k < 200) begin sample(); ok = bready; tick(); k++; end
    bvalid = 0;
    check("b_accepted", ok, 1);
  endtask

  task automatic wait_beats(input int n);
    int k = 0;
    while (beats < n && k < 3000) begin sample(); k++; end
    check("beats_reached", beats >= n, 1);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (len_q.size() != 0 && k < 5000) begin sample(); k++; end
    check("drained", len_q.size() == 0, 1);
  endtask

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    foreach (data_mem[i]) data_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    reset = 1; cmd_valid = 0; cmd_len = 0; bvalid = 0; bresp = 0; bid = 0; err_clr = 0;
    repeat (3) tick();
    reset = 0;
    sample();
    check("rst_err", err, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_s_ready", s_ready, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_wlast", wlast, 0);
    check("rst_bready", bready, 0);
    check("rst_idle", idle, 1);

    // single 1-beat burst, latency N+2
    s_mode = 1; w_mode = 1; beats = 0; lasts = 0;
    tick(); cmd_valid = 1; cmd_len = 0;
    tick(); cmd_valid = 0;
    sample(); check("t1_wvalid_n1", wvalid, 0);
    sample(); check("t1_wvalid_n2", wvalid, 1); check("t1_wlast_n2", wlast, 1);
    repeat (3) sample();
    check("t1_beats", beats, 1);
    send_b(2'b00);
    sample(); check("t1_idle", idle, 1);

    // 16-beat burst with random gaps and stalls
    s_mode = 2; w_mode = 2; beats = 0; lasts = 0;
    send_cmd(15); wait_beats(16);
    repeat (10) sample();
    check("t2_beats", beats, 16);
    check("t2_lasts", lasts, 1);
    send_b(2'b00);

    // back-to-back bursts 3, 15, 0
    s_mode = 1; w_mode = 1; beats = 0; lasts = 0; last_pos.delete();
    tick(); cmd_valid = 1; cmd_len = 3;
    tick(); cmd_len = 15;
    tick(); cmd_len = 0;
    tick(); cmd_valid = 0;
    wait_beats(21);
    repeat (4) sample();
    check("t3_beats", beats, 21);
    check("t3_lasts", last_pos.size(), 3);
    check("t3_last0", last_pos.size() > 0 ? last_pos[0] : -1, 4);
    check("t3_last1", last_pos.size() > 1 ? last_pos[1] : -1, 20);
    check("t3_last2", last_pos.size() > 2 ? last_pos[2] : -1, 21);
    check("t3_contiguous", last_cyc - first_cyc, 20);
    repeat (3) send_b(2'b00);
    sample(); check("t3_idle", idle, 1);

    // outstanding limit
    pushes = 0;
    tick(); cmd_len = 0; cmd_valid = 1;
    repeat (6) tick();
    sample();
    check("t4_pushes_cap", pushes, 4);
    check("t4_ready_low", cmd_ready, 0);
    send_b(2'b00);
    sample(); check("t4_slot_free", cmd_ready, 1);
    tick(); cmd_valid = 0;
    sample(); check("t4_pushes5", pushes, 5); check("t4_refull", cmd_ready, 0);
    send_b(2'b00);
    cmd_valid = 1; bvalid = 1; bresp = 2'b00;
    sample(); check("t4_simul_bready", bready, 1); check("t4_simul_ready", cmd_ready, 1);
    tick(); cmd_valid = 0; bvalid = 0;
    sample(); check("t4_simul_keep", cmd_ready, 1); check("t4_pushes6", pushes, 6);
    tick(); cmd_valid = 1;
    tick(); cmd_valid = 0;
    sample(); check("t4_full_again", cmd_ready, 0); check("t4_pushes7", pushes, 7);
    repeat (4) send_b(2'b00);
    sample(); check("t4_idle", idle, 1);

    // sticky error
    send_cmd(0); send_b(2'b10);
    sample(); check("t5_err_set", err, 1);
    repeat (3) tick();
    sample(); check("t5_err_sticky", err, 1);
    tick(); err_clr = 1;
    tick(); err_clr = 0;
    sample(); check("t5_err_clr", err, 0);
    send_cmd(0);
    tick(); err_clr = 1; bvalid = 1; bresp = 2'b10;
    sample(); check("t5_simul_bready", bready, 1);
    tick(); err_clr = 0; bvalid = 0;
    sample(); check("t5_set_wins", err, 1);
    tick(); err_clr = 1;
    tick(); err_clr = 0;
    send_cmd(0); send_b(2'b11);
    sample(); check("t5_decerr", err, 1);
    tick(); err_clr = 1;
    tick(); err_clr = 0;
    sample(); check("t5_err_clr2", err, 0);

    // reset mid-burst
    beats = 0; lasts = 0;
    send_cmd(15); wait_beats(5);
    tick(); reset = 1;
    #1;
    check("t6_beats", beats, 5);
    check("t6_wvalid", wvalid, 0);
    check("t6_idle", idle, 1);
    check("t6_cmd_ready", cmd_ready, 1);
    check("t6_s_ready", s_ready, 0);
    repeat (2) tick();
    reset = 0; beats = 0; lasts = 0;
    send_cmd(1); wait_beats(2);
    repeat (5) sample();
    check("t6_new_beats", beats, 2);
    check("t6_new_lasts", lasts, 1);
    send_b(2'b00);
    sample(); check("t6_idle_end", idle, 1);

    // randomized rounds
    s_mode = 2; w_mode = 2;
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) send_cmd($urandom_range(0, 20));
      wait_drain();
      for (int i = 0; i < n; i++) send_b(2'($urandom_range(0, 3)));
      tick(); err_clr = 1;
      tick(); err_clr = 0;
    end
    repeat (2) sample();
    check("final_idle", idle, 1);
    check("final_err", err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
